io_controller: RTL and testbench

- Sequences the processor's IN and OUT instructions against the board I/O.
- On an IN opcode it stalls the processor, waits for a debounced press of the `enter` pushbutton, latches the switch word and releases the stall for exactly one cycle.
- On an OUT opcode it latches RDvalue into a held display register.
- Sits between the board pins and the Processor's IN_Data input and stall/PC-enable path, alongside the ControlUnit.

---
 rtl/io_controller.sv | 153 +++++++++++++++
 tb/tb_io_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_controller.sv
// io_controller: sequences IN/OUT instructions against the board I/O.
// IN stalls the processor until a debounced release-then-press of `enter`,
// latches the switch word and frees the pipeline for one cycle; OUT latches
// RDvalue into a held display register with a one-cycle update pulse.
module io_controller #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [5:0] OP_IN           = 6'd30,
    parameter logic [5:0] OP_OUT          = 6'd31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        enter,
    input  logic [31:0] IN_switches,
    input  logic [31:0] RDvalue,
    output logic [31:0] IN_Data,
    output logic        stall,
    output logic [31:0] OUT,
    output logic        flagOUT,
    output logic        LED
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the last qualifying cycle of a debounce window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_PRESS,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stall_raw;

    logic             enter_p0;
    logic             enter_p1;
    logic             enter_s;

    logic             is_in;
    logic             is_out;

    assign is_in   = (opcode == OP_IN);
    assign is_out  = (opcode == OP_OUT);
    assign enter_s = enter_p1;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_p0 <= 1'b0;
            enter_p1 <= 1'b0;
        end else begin
            enter_p0 <= enter;
            enter_p1 <= enter_p0;
        end
    end

    // FSM state and debounce counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, debounce counting, stall request and operator LED.
    // The counter only advances while enter_s matches the level being
    // qualified; any other sample or any state change returns it to zero.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        stall_raw  = 1'b0;
        LED        = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_in) begin
                    stall_raw  = 1'b1;
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                // Require a clean release first so a button still held
                // from the previous IN cannot satisfy this one.
                stall_raw = 1'b1;
                LED       = 1'b1;
                if (!enter_s) begin
                    if (cnt == CNT_LAST) begin
                        state_next = S_WAIT_PRESS;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            S_WAIT_PRESS: begin
                stall_raw = 1'b1;
                LED       = 1'b1;
                if (enter_s) begin
                    if (cnt == CNT_LAST) begin
                        state_next = S_CAPTURE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            S_CAPTURE: begin
                stall_raw  = 1'b1;
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                // The IN instruction retires here; PC advances this edge.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Reset overrides the IDLE+OP_IN decode so the processor is never
    // held while the controller itself is being reset.
    assign stall = stall_raw & ~reset;

    // Switch word latch, loaded only in CAPTURE and held until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IN_Data <= '0;
        end else if (state == S_CAPTURE) begin
            IN_Data <= IN_switches;
        end
    end

    // Display register and its one-cycle update pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            OUT     <= '0;
            flagOUT <= 1'b0;
        end else if (is_out && !stall) begin
            OUT     <= RDvalue;
            flagOUT <= 1'b1;
        end else begin
            flagOUT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// Testbench for io_controller: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_io_controller;

    localparam int         D      = 4;
    localparam logic [5:0] OP_IN  = 6'd30;
    localparam logic [5:0] OP_OUT = 6'd31;

    logic        clock;
    logic        reset;
    logic [5:0]  opcode;
    logic        enter;
    logic [31:0] IN_switches;
    logic [31:0] RDvalue;
    logic [31:0] IN_Data;
    logic        stall;
    logic [31:0] OUT;
    logic        flagOUT;
    logic        LED;

    int n_checks;
    int n_errors;

    // Reference model: an IN in progress is described by how many more
    // clean low samples and clean high samples it still needs.
    bit          m_active;
    bit          m_capture;
    bit          m_release;
    int          lows_left;
    int          highs_left;
    logic [31:0] m_in;
    logic [31:0] m_out;
    bit          m_flag;
    bit          dly0;
    bit          dly1;

    bit          pat_q[$];

    io_controller #(
        .DEBOUNCE_CYCLES(D),
        .OP_IN(OP_IN),
        .OP_OUT(OP_OUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .opcode(opcode),
        .enter(enter),
        .IN_switches(IN_switches),
        .RDvalue(RDvalue),
        .IN_Data(IN_Data),
        .stall(stall),
        .OUT(OUT),
        .flagOUT(flagOUT),
        .LED(LED)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit exp_stall(input logic [5:0] op);
        bit idle;
        idle = !m_active && !m_capture && !m_release;
        return (reset === 1'b0) && (m_active || m_capture || (idle && op == OP_IN));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall",   32'(stall),   32'(exp_stall(opcode)));
        chk("led",     32'(LED),     32'(m_active));
        chk("in_data", IN_Data,      m_in);
        chk("out",     OUT,          m_out);
        chk("flagout", 32'(flagOUT), 32'(m_flag));
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_capture  = 0;
        m_release  = 0;
        lows_left  = 0;
        highs_left = 0;
        m_in       = '0;
        m_out      = '0;
        m_flag     = 0;
        dly0       = 0;
        dly1       = 0;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        bit es;
        bit st;
        es   = dly1;
        dly1 = dly0;
        dly0 = enter;
        st   = exp_stall(opcode);
        if (opcode == OP_OUT && !st) begin
            m_out  = RDvalue;
            m_flag = 1;
        end else begin
            m_flag = 0;
        end
        if (m_release) begin
            m_release = 0;
        end else if (m_capture) begin
            m_in      = IN_switches;
            m_capture = 0;
            m_release = 1;
        end else if (m_active) begin
            if (lows_left > 0) begin
                if (!es) lows_left--;
                else     lows_left = D;
            end else begin
                if (es) highs_left--;
                else    highs_left = D;
                if (highs_left == 0) begin
                    m_active  = 0;
                    m_capture = 1;
                end
            end
        end else if (opcode == OP_IN) begin
            m_active   = 1;
            lows_left  = D;
            highs_left = D;
        end
    endtask

    // One clock: apply inputs after the falling edge, compare, then step.
    task automatic cycle(input logic [5:0] op, input logic en,
                         input logic [31:0] sw, input logic [31:0] rd);
        opcode      = op;
        enter       = en;
        IN_switches = sw;
        RDvalue     = rd;
        #1;
        check_all();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_stall",   32'(stall),   32'd0);
        chk("rst_led",     32'(LED),     32'd0);
        chk("rst_in_data", IN_Data,      32'd0);
        chk("rst_out",     OUT,          32'd0);
        chk("rst_flagout", 32'(flagOUT), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic add_run(input bit v, input int len);
        repeat (len) pat_q.push_back(v);
    endtask

    // Issue OP_IN until the model reaches the release cycle, replaying the
    // enter pattern in pat_q (last level held once it runs out), then run
    // the release cycle. n = cycles spent stalled before release.
    task automatic exec_in(input logic [31:0] sw, output int n);
        bit lvl;
        lvl = enter;
        n   = 0;
        while (!m_release && n < 200) begin
            if (pat_q.size() > 0) lvl = pat_q.pop_front();
            cycle(OP_IN, lvl, sw, $urandom);
            n++;
        end
        cycle(OP_IN, lvl, sw, $urandom);
        pat_q.delete();
    endtask

    initial begin
        int n;
        int run;
        bit lvl;
        int r;
        logic [5:0] op;

        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        opcode      = '0;
        enter       = 1'b0;
        IN_switches = '0;
        RDvalue     = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        cycle(6'd0, 1'b0, 32'h0, 32'h0);
        cycle(6'd1, 1'b0, 32'h0, 32'h0);

        // OUT: update, one-cycle pulse, hold, consecutive updates
        cycle(OP_OUT, 1'b0, 32'h0, 32'hDEAD_BEEF);
        chk("out_value", OUT, 32'hDEAD_BEEF);
        chk("out_flag",  32'(flagOUT), 32'd1);
        cycle(6'd2, 1'b0, 32'h0, 32'h0);
        chk("out_hold",  OUT, 32'hDEAD_BEEF);
        chk("out_flag_clear", 32'(flagOUT), 32'd0);
        repeat (3) cycle(OP_OUT, 1'b0, 32'h0, $urandom);

        // Reset while an IN is arming, with OP_IN still on the bus
        cycle(OP_IN, 1'b0, 32'h0, 32'h0);
        cycle(OP_IN, 1'b0, 32'h0, 32'h0);
        do_reset();

        // Basic IN
        add_run(1'b0, 5);
        add_run(1'b1, 10);
        exec_in(32'h0000_00A5, n);
        chk("basic_len",  32'(n),  32'd12);
        chk("basic_data", IN_Data, 32'h0000_00A5);
        opcode = 6'd3;
        #1;
        chk("basic_next_unstalled", 32'(stall), 32'd0);
        cycle(6'd3, 1'b0, 32'h0, 32'h0);

        // Button already held when OP_IN arrives, then a bounce while waiting
        repeat (3) cycle(6'd3, 1'b1, 32'hFFFF_FFFF, 32'h0);
        add_run(1'b1, 8);
        add_run(1'b0, 6);
        add_run(1'b1, 2);
        add_run(1'b0, 1);
        add_run(1'b1, 3);
        add_run(1'b1, 8);
        exec_in(32'h0000_00C3, n);
        chk("held_len",  32'(n),  32'd24);
        chk("held_data", IN_Data, 32'h0000_00C3);
        cycle(6'd3, 1'b0, 32'h0, 32'h0);

        // Back-to-back IN; the second must see a fresh release and press
        add_run(1'b0, 5);
        add_run(1'b1, 6);
        exec_in(32'h1, n);
        chk("b2b1_len",  32'(n),  32'd12);
        chk("b2b1_data", IN_Data, 32'h1);
        add_run(1'b1, 8);
        add_run(1'b0, 6);
        add_run(1'b1, 6);
        exec_in(32'h2, n);
        chk("b2b2_len",  32'(n),  32'd21);
        chk("b2b2_data", IN_Data, 32'h2);
        cycle(6'd3, 1'b0, 32'h0, 32'h0);

        // Reset during WAIT_PRESS with enter high, then restart from ARM
        repeat (5) cycle(OP_IN, 1'b0, 32'h77, 32'h0);
        repeat (4) cycle(OP_IN, 1'b1, 32'h77, 32'h0);
        chk("wait_led", 32'(LED), 32'd1);
        do_reset();
        add_run(1'b1, 6);
        add_run(1'b0, 6);
        add_run(1'b1, 6);
        exec_in(32'h0000_005A, n);
        chk("restart_len",  32'(n),  32'd19);
        chk("restart_data", IN_Data, 32'h0000_005A);

        // Randomized traffic
        run = 0;
        lvl = 1'b0;
        repeat (1500) begin
            r = $urandom_range(0, 299);
            if (r == 0) do_reset();
            r = $urandom_range(0, 9);
            if (r < 4)      op = OP_IN;
            else if (r < 7) op = OP_OUT;
            else            op = 6'($urandom);
            if (run == 0) begin
                lvl = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 8);
            end
            run--;
            cycle(op, lvl, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
